// File: rtl/kbd_pkg.sv
// Shared constants, decoder state encoding and the scan-code-set-2 letter lookup
// for the PS/2 keyboard front end.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [4:0] LETTER_NONE  = 5'd0;
    localparam logic [4:0] RELEASE_CODE = 5'd21;

    typedef enum logic [1:0] {
        MAKE,
        BREAK,
        EXT,
        EXT_BREAK
    } dec_state_e;

    // A..T map to 1..20, U..Z skip the release code and map to 22..27.
    function automatic logic [4:0] letter_lookup(input logic [7:0] sc);
        logic [4:0] code;
        code = LETTER_NONE;
        case (sc)
            8'h1C: code = 5'd1;
            8'h32: code = 5'd2;
            8'h21: code = 5'd3;
            8'h23: code = 5'd4;
            8'h24: code = 5'd5;
            8'h2B: code = 5'd6;
            8'h34: code = 5'd7;
            8'h33: code = 5'd8;
            8'h43: code = 5'd9;
            8'h3B: code = 5'd10;
            8'h42: code = 5'd11;
            8'h4B: code = 5'd12;
            8'h3A: code = 5'd13;
            8'h31: code = 5'd14;
            8'h44: code = 5'd15;
            8'h4D: code = 5'd16;
            8'h15: code = 5'd17;
            8'h2D: code = 5'd18;
            8'h1B: code = 5'd19;
            8'h2C: code = 5'd20;
            8'h3C: code = 5'd22;
            8'h2A: code = 5'd23;
            8'h1D: code = 5'd24;
            8'h22: code = 5'd25;
            8'h35: code = 5'd26;
            8'h1A: code = 5'd27;
            default: code = LETTER_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the pins, shifts 11-bit frames and checks them.
// byte_valid_o / frame_err_o pulse the cycle after the stop-bit edge; no backpressure.
module ps2_rx_frame #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kbdclk_i,
    input  logic       kbddat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_vld_q, byte_vld_d;
    logic                   err_q, err_d;
    logic                   clk_s, dat_s, fall;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        if (fall) begin
            // An edge always restarts the idle count, even on a terminal-count cycle.
            tmo_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                // shift_q holds start at [0], data at [8:1], parity at [9]; dat_s is stop.
                if (!shift_q[0] && dat_s && (^shift_q[9:1])) begin
                    byte_d     = shift_q[8:1];
                    byte_vld_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_s, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = 4'd0;
                tmo_d     = '0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            tmo_q      <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kbdclk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kbddat_i};
            clk_prev_q <= clk_s;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_vld_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/kbd_letter_decoder.sv
// PS/2 keyboard to 5-bit letter code; letter updates 2 cycles after the stop-bit edge
// is detected, letter_valid pulses on every write; no backpressure (events are dropped never queued).
module kbd_letter_decoder #(
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter int         SYNC_STAGES    = 2,
    parameter logic [4:0] RELEASE_CODE   = kbd_pkg::RELEASE_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       frame_err
);
    import kbd_pkg::*;

    logic [7:0] rx_byte;
    logic       rx_vld;
    dec_state_e state_q, state_d;
    logic [4:0] letter_q, letter_d;
    logic       letter_vld_q, letter_vld_d;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .kbdclk_i    (kbdclk),
        .kbddat_i    (kbddat),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_vld),
        .frame_err_o (frame_err)
    );

    always_comb begin
        state_d      = state_q;
        letter_d     = letter_q;
        letter_vld_d = 1'b0;
        if (rx_vld) begin
            case (state_q)
                MAKE: begin
                    if (rx_byte == SC_BREAK) begin
                        letter_d     = RELEASE_CODE;
                        letter_vld_d = 1'b1;
                        state_d      = BREAK;
                    end else if (rx_byte == SC_EXT) begin
                        state_d = EXT;
                    end else begin
                        letter_d     = letter_lookup(rx_byte);
                        letter_vld_d = 1'b1;
                    end
                end
                BREAK:     state_d = MAKE;
                EXT:       state_d = (rx_byte == SC_BREAK) ? EXT_BREAK : MAKE;
                EXT_BREAK: state_d = MAKE;
                default:   state_d = MAKE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MAKE;
            letter_q     <= LETTER_NONE;
            letter_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            letter_q     <= letter_d;
            letter_vld_q <= letter_vld_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_vld_q;

endmodule

// File: tb/tb_kbd_letter_decoder.sv
// Bench for kbd_letter_decoder: directed vector table, hand sequences, then random frames
// compared against a token-level reference model.
module tb_kbd_letter_decoder;
    localparam int TO   = 400;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbdclk = 1'b1;
    logic       kbddat = 1'b1;
    logic [4:0] letter;
    logic       letter_valid;
    logic       frame_err;

    kbd_letter_decoder #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2),
        .RELEASE_CODE  (5'd21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kbdclk      (kbdclk),
        .kbddat      (kbddat),
        .letter      (letter),
        .letter_valid(letter_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int lv_cnt = 0;
    int fe_cnt = 0;
    int lv_cyc = 0;
    int stop_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (letter_valid) begin
            lv_cnt++;
            lv_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
    end

    // Scan codes in alphabetical order A..Z.
    logic [7:0] scan_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 26; i++)
            if (scan_tab[i] == b) return (i < 20) ? i + 1 : i + 2;
        return 0;
    endfunction

    // Reference model: parses the byte stream into tokens (X, F0 X, E0 X, E0 F0 X).
    logic [7:0] pend[$];
    int         m_letter = 0;

    task automatic model_byte(input logic [7:0] b, output bit wr);
        wr = 1'b0;
        pend.push_back(b);
        if (pend.size() == 1) begin
            if (b == 8'hF0) begin
                m_letter = 21;
                wr = 1'b1;
            end else if (b != 8'hE0) begin
                m_letter = lookup(b);
                wr = 1'b1;
                pend.delete();
            end
        end else if (pend.size() == 2) begin
            if (!(pend[0] == 8'hE0 && b == 8'hF0)) pend.delete();
        end else begin
            pend.delete();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit badpar, input int first, input int last);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = first; i <= last; i++) begin
            kbddat = f[i];
            repeat (HALF) @(posedge clk);
            #1;
            kbdclk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(posedge clk);
            #1;
            kbdclk = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit badpar, input int exp_letter,
                             input bit exp_lv, input bit exp_fe, input string name);
        int lv0, fe0;
        lv0 = lv_cnt;
        fe0 = fe_cnt;
        send_bits(b, badpar, 0, 10);
        repeat (30) @(posedge clk);
        #1;
        chk({name, " letter_valid count"}, lv_cnt - lv0, int'(exp_lv));
        chk({name, " frame_err count"}, fe_cnt - fe0, int'(exp_fe));
        chk({name, " letter"}, int'(letter), exp_letter);
        if (exp_lv && (lv_cnt - lv0) == 1)
            chk({name, " latency"}, lv_cyc - stop_cyc, 4);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         bad;
        int         exp_letter;
        bit         exp_lv;
        bit         exp_fe;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic [7:0] b, input bit bad, input int l, input bit lv, input bit fe);
        vec_t v;
        v.b = b; v.bad = bad; v.exp_letter = l; v.exp_lv = lv; v.exp_fe = fe;
        tab.push_back(v);
    endtask

    initial begin
        int lv0, fe0;
        bit wr;
        logic [7:0] b;
        bit bad;
        int exp_l;

        add(8'h1C, 0, 1, 1, 0);
        add(8'h1C, 0, 1, 1, 0);
        add(8'hF0, 0, 21, 1, 0);
        add(8'h1C, 0, 21, 0, 0);
        add(8'h3C, 0, 22, 1, 0);
        add(8'h2A, 1, 22, 0, 1);
        add(8'h1A, 0, 27, 1, 0);
        add(8'hE0, 0, 27, 0, 0);
        add(8'h75, 0, 27, 0, 0);
        add(8'hE0, 0, 27, 0, 0);
        add(8'hF0, 0, 27, 0, 0);
        add(8'h75, 0, 27, 0, 0);
        add(8'h76, 0, 0, 1, 0);
        add(8'h2C, 0, 20, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset letter", int'(letter), 0);
        chk("reset letter_valid", int'(letter_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < tab.size(); i++)
            run_frame(tab[i].b, tab[i].bad, tab[i].exp_letter, tab[i].exp_lv, tab[i].exp_fe,
                      $sformatf("vec%0d", i));

        // Partial frame then idle well past the timeout.
        lv0 = lv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h55, 0, 0, 4);
        repeat (TO + TO / 2) @(posedge clk);
        #1;
        chk("timeout frame_err count", fe_cnt - fe0, 1);
        chk("timeout letter_valid count", lv_cnt - lv0, 0);
        chk("timeout letter", int'(letter), 20);
        run_frame(8'h15, 0, 17, 1, 0, "after timeout");
        run_frame(8'h24, 0, 5, 1, 0, "before reset");

        // Reset mid-frame.
        send_bits(8'h24, 0, 0, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid-frame reset letter", int'(letter), 0);
        chk("mid-frame reset letter_valid", int'(letter_valid), 0);
        lv0 = lv_cnt;
        send_bits(8'h24, 0, 4, 10);
        repeat (TO + 200) @(posedge clk);
        #1;
        chk("aborted remainder letter_valid count", lv_cnt - lv0, 0);
        chk("aborted remainder letter", int'(letter), 0);
        run_frame(8'h24, 0, 5, 1, 0, "after reset");

        // Random phase against the model, from a clean reset.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pend.delete();
        m_letter = 0;
        repeat (5) @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(9, 0))
                0, 1, 2, 3, 4: b = scan_tab[$urandom_range(25, 0)];
                5, 6:          b = 8'hF0;
                7:             b = 8'hE0;
                default:       b = 8'($urandom_range(255, 0));
            endcase
            bad = ($urandom_range(9, 0) == 0);
            wr = 1'b0;
            if (!bad) model_byte(b, wr);
            exp_l = m_letter;
            run_frame(b, bad, exp_l, wr, bad, $sformatf("rand%0d byte %02h", n, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
